// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with per-register busy bits for tracking pending
// producers; combinational reads with optional write-to-read forwarding.
module regfile_scoreboard #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int NRD    = 4,
  parameter int NWR    = 2,
  parameter int NISS   = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_ready,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NISS-1:0]      iss_en,
  input  logic [NISS*AW-1:0]   iss_addr,
  output logic [NISS-1:0]      iss_accept,
  output logic [CW-1:0]        busy_count
);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] wr_hit;
  logic [CW-1:0]    busy_cnt_next;
  logic             dup;

  // Registers written this cycle; x0 is never considered written.
  always_comb begin
    wr_hit = '0;
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
        wr_hit[wr_addr[j*AW +: AW]] = 1'b1;
  end

  always_comb begin
    iss_accept = '0;
    dup        = 1'b0;
    for (int k = 0; k < NISS; k++) begin
      if (iss_en[k]) begin
        if (iss_addr[k*AW +: AW] == '0) begin
          iss_accept[k] = 1'b1;
        end else if (!busy[iss_addr[k*AW +: AW]] || wr_hit[iss_addr[k*AW +: AW]]) begin
          // A lower-indexed port claiming the same register takes priority.
          dup = 1'b0;
          for (int m = 0; m < k; m++)
            if (iss_en[m] && iss_addr[m*AW +: AW] == iss_addr[k*AW +: AW])
              dup = 1'b1;
          iss_accept[k] = !dup;
        end
      end
    end
  end

  // Clear-on-write first, then set-on-reserve so a new producer wins.
  always_comb begin
    busy_next = busy & ~wr_hit;
    for (int k = 0; k < NISS; k++)
      if (iss_accept[k] && iss_addr[k*AW +: AW] != '0)
        busy_next[iss_addr[k*AW +: AW]] = 1'b1;
    busy_next[0] = 1'b0;
    busy_cnt_next = '0;
    for (int r = 0; r < NREGS; r++)
      busy_cnt_next = busy_cnt_next + CW'(busy_next[r]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_cnt_next;
    end
  end

  // Later ports' non-blocking writes override earlier ones on an address clash.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++)
        mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
    end
  end

  always_comb begin
    rd_data  = '0;
    rd_ready = '0;
    for (int i = 0; i < NRD; i++) begin
      if (rd_addr[i*AW +: AW] != '0) begin
        rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
        if (BYPASS != 0)
          for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])
              rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
      end
      rd_ready[i] = (rd_addr[i*AW +: AW] == '0) || !busy[rd_addr[i*AW +: AW]] ||
                    ((BYPASS != 0) && wr_hit[rd_addr[i*AW +: AW]]);
    end
  end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter XLEN, default 64, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count; AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 4, number of read ports.
REQ-004 SHALL have parameter NWR, default 2, number of write ports.
REQ-005 SHALL have parameter NISS, default 2, number of issue (destination-reserve) ports.
REQ-006 SHALL have parameter BYPASS, default 1; 1 enables write-to-read forwarding.
REQ-007 SHALL use one clock and a synchronous, active-low reset.
REQ-008 clk  in  1  rising-edge clock for all state.
REQ-009 rst_n  in  1  synchronous active-low reset.
REQ-010 rd_addr  in  NRD*AW  packed read addresses; port i in bits [i*AW +: AW].
REQ-011 rd_data  out  NRD*XLEN  packed read data.
REQ-012 rd_ready  out  NRD  operand i available (not pending).
REQ-013 wr_en  in  NWR  write enables.
REQ-014 wr_addr  in  NWR*AW  packed write addresses.
REQ-015 wr_data  in  NWR*XLEN  packed write data.
REQ-016 iss_en  in  NISS  destination reservation requests.
REQ-017 iss_addr  in  NISS*AW  packed destination addresses.
REQ-018 iss_accept  out  NISS  reservation granted this cycle (combinational).
REQ-019 busy_count  out  clog2(NREGS+1)  number of registers currently pending.

Function
REQ-020 Storage SHALL be NREGS x XLEN; writes occur only at the rising edge of clk when wr_en[j]=1.
REQ-021 Register 0 SHALL read as zero always; writes to and reservations of address 0 SHALL be ignored, and iss_accept SHALL be 1 for address 0.
REQ-022 Same-cycle writes to one address SHALL resolve in favour of the highest-indexed write port.
REQ-023 Reads SHALL be combinational; with BYPASS=0, rd_data returns the stored value.
REQ-024 With BYPASS=1, rd_data SHALL return wr_data of the highest-indexed enabled write port matching rd_addr (nonzero), else the stored value.
REQ-025 Each register SHALL have a busy bit; an accepted reservation sets it at the next edge; a write to that address clears it at the next edge.
REQ-026 Same-cycle write-clear and accepted reservation on one address SHALL leave busy=1 (new producer wins).
REQ-027 iss_accept[k] SHALL be 1 iff iss_en[k]=1 and the target is not busy, or is busy but written this cycle.
REQ-028 Two issue ports targeting one nonzero address in the same cycle: only the lowest-indexed port SHALL be accepted.
REQ-029 rd_ready[i] SHALL be 1 iff the address is 0, not busy, or (BYPASS=1 and written this cycle).
REQ-030 busy_count SHALL equal the number of set busy bits, registered and updated with them; never exceeds NREGS-1.
REQ-031 Writes to a non-busy register SHALL update data and leave busy at 0.

Reset
REQ-032 When rst_n=0 at an edge, all registers SHALL become 0, all busy bits 0 and busy_count 0; writes and reservations that cycle SHALL be discarded.
REQ-033 Reset asserted mid-operation SHALL cancel all pending reservations; after release, all rd_ready=1 and rd_data=0.

Verification
REQ-034 Reset then read x5 on all ports -> rd_data=0, rd_ready=1, busy_count=0.
REQ-035 Write 0x1234 to x7 on port 0 and 0xABCD to x7 on port 1 same cycle, read x7 next cycle -> 0xABCD.
REQ-036 BYPASS=1: write 0x55 to x3 while reading x3 same cycle -> rd_data=0x55, rd_ready=1; BYPASS=0 -> old value.
REQ-037 Reserve x9 (accept=1) -> next cycle rd_ready for x9=0, busy_count=1; second reserve of x9 -> accept=0; write x9 -> following cycle rd_ready=1, busy_count=0.
REQ-038 Write x9 and reserve x9 same cycle -> accept=1, busy stays 1, data updated; both issue ports reserve x12 same cycle -> accept=2'b01.
REQ-039 Write 0xFF to x0 and reserve x0 -> reads of x0 return 0, rd_ready=1, busy_count unchanged; rst_n=0 with 3 busy registers -> busy_count=0 next cycle.
